npu_result_requant_packer: RTL and testbench
============================================

Name: npu_result_requant_packer

Overview:
Consumer-side companion to the 16-MAC dot-product unit. It takes each registered 32-bit signed dot-product result (result/valid pulse, no backpressure) and requantizes it to INT8: bias add, fixed-point scale, rounding shift, optional ReLU, saturation. Four INT8 bytes are packed into a 32-bit word, and words are buffered in a small FIFO. The FIFO drains over a valid/ready interface toward the activation write-back path.

Parameters:
FIFO_DEPTH, 4, number of 32-bit packed words buffered (power of two, ≥2)

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
res_data  input  32  signed dot-product result
res_valid  input  1  res_data valid this cycle; one-cycle pulses, may be back-to-back
bias  input  32  signed bias, sampled with res_valid
scale_mult  input  16  unsigned multiplier, sampled with res_valid
scale_shift  input  5  right-shift amount 0..31, sampled with res_valid
relu_en  input  1  clamp negatives to 0, sampled with res_valid
flush  input  1  one-cycle pulse; emit partially packed word
ovf_clr  input  1  clears overflow flag
out_data  output  32  packed word; byte k in bits [8k+7:8k], k=0 oldest
out_bytes  output  3  number of valid bytes in out_data, 1..4
out_valid  output  1  FIFO head valid
out_ready  input  1  downstream accepts head
overflow  output  1  sticky: a word was dropped because the FIFO was full
busy  output  1  any data in pipeline, packer, FIFO, or a pending flush

Behaviour:
- Reset (async, rst_n=0): all pipeline valids=0, packer count=0, FIFO empty, flush_pending=0. Outputs: out_data=0, out_bytes=0, out_valid=0, overflow=0, busy=0.
- Clock and reset ports are clk and rst_n. Reset is asynchronous, active-low, single clock domain.
- Pipeline, 3 stages. Per-item config (bias, mult, shift, relu) is captured in S1 and carried alongside the data.
  - S1: acc = sext33(res_data) + sext33(bias). 33-bit, no wrap.
  - S2: prod = acc × {1'b0, scale_mult}. 50-bit signed.
  - S3: if shift>0, r = (prod + (1<<(shift-1))) >>> shift, i.e. round half toward +inf; else r = prod. If relu_en and r<0, r=0. Saturate to [-128,127].
  - The byte reaches the packer 3 cycles after res_valid. Full throughput: 1 result per cycle.
- Packer:
  - Byte is written at index = count; count increments.
  - When count reaches 4, the word is pushed with out_bytes=4 in the same cycle the 4th byte arrives, and count returns to 0.
- Flush:
  - Sets flush_pending.
  - Executes on the first cycle when S1–S3 are all empty and no byte enters the packer.
  - On execution: if count>0, push the word with unused upper bytes =0 and out_bytes=count, then count=0. If count=0, nothing is pushed.
  - flush_pending then clears. A flush while already pending has no extra effect.
  - res_valid arriving while flush_pending delays execution until that item drains; the item is included in the flushed word.
- FIFO:
  - out_valid = not empty. out_data/out_bytes show the head and are stable while out_valid & !out_ready. Pop on out_valid & out_ready.
  - Push when full with no pop that cycle: the word is dropped and overflow←1. Push when full with simultaneous pop: accepted.
  - ovf_clr clears overflow. If a drop and ovf_clr occur in the same cycle, the drop wins (overflow=1).
- busy = any Sx valid | count≠0 | FIFO not empty | flush_pending. Registered-state derived; may be combinational from regs.
- No backpressure to the dot-product unit. Upstream control must respect FIFO capacity; overflow is the only indication.

Test Plan:
1. bias=0, mult=1, shift=0, relu=0; results 1,2,3,4 on consecutive cycles -> one word 0x04030201, out_bytes=4, out_valid rises 3 cycles after the 4th res_valid.
2. Saturation/ReLU: mult=1, shift=0; results 1000, -1000, then -1000 with relu=1, then 100 with bias=27 -> word 0x7F00807F.
3. Rounding: mult=1, shift=1; results 3, -3, 5, -5 -> bytes 2, -1, 3, -2 -> 0xFE03FF02. Repeat with mult=3, shift=2, result 10 -> (30+2)>>2=8.
4. Flush: two results 0x10, 0x20, flush pulse on the cycle of the 2nd res_valid -> 0x00002010, out_bytes=2. A further flush with count=0 -> no push.
5. Overflow: FIFO_DEPTH=2, out_ready=0, 12 back-to-back results -> 2 words held, 3rd dropped, overflow=1. Then out_ready=1 drains 2 intact words in order. ovf_clr -> overflow=0.
6. Reset mid-operation: assert rst_n=0 with 2 items in the pipeline, count=3, FIFO holding 1 word -> all outputs 0 immediately. After release, a fresh 4-result sequence yields only the new word.

Source files
------------

// File: rtl/npu_result_requant_packer.sv
// Requantizes 32-bit dot-product results to INT8 (bias, scale, rounding shift, ReLU, saturate),
// packs four bytes per word and buffers the words in a small valid/ready FIFO.
module npu_result_requant_packer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] res_data,
  input  logic        res_valid,
  input  logic [31:0] bias,
  input  logic [15:0] scale_mult,
  input  logic [4:0]  scale_shift,
  input  logic        relu_en,
  input  logic        flush,
  input  logic        ovf_clr,
  output logic [31:0] out_data,
  output logic [2:0]  out_bytes,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic        busy
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(FIFO_DEPTH);

  // S1: bias add, config captured alongside the data
  logic               s1_valid_q;
  logic signed [32:0] s1_acc_q;
  logic [15:0]        s1_mult_q;
  logic [4:0]         s1_shift_q;
  logic               s1_relu_q;

  // S2: scaled product
  logic               s2_valid_q;
  logic signed [49:0] s2_prod_q;
  logic [4:0]         s2_shift_q;
  logic               s2_relu_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_acc_q   <= '0;
      s1_mult_q  <= '0;
      s1_shift_q <= '0;
      s1_relu_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      s2_shift_q <= '0;
      s2_relu_q  <= 1'b0;
    end else begin
      s1_valid_q <= res_valid;
      if (res_valid) begin
        s1_acc_q   <= $signed({res_data[31], res_data}) + $signed({bias[31], bias});
        s1_mult_q  <= scale_mult;
        s1_shift_q <= scale_shift;
        s1_relu_q  <= relu_en;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_prod_q  <= 50'(s1_acc_q) * 50'($signed({1'b0, s1_mult_q}));
        s2_shift_q <= s1_shift_q;
        s2_relu_q  <= s1_relu_q;
      end
    end
  end

  // S3: round half toward +inf, ReLU, saturate; feeds the packer directly
  logic signed [50:0] s3_rnd;
  logic signed [50:0] s3_sum;
  logic signed [50:0] s3_r;
  logic [7:0]         s3_byte;

  always_comb begin
    s3_rnd = '0;
    if (s2_shift_q != 5'd0) begin
      s3_rnd = 51'sd1 <<< (s2_shift_q - 5'd1);
    end
    s3_sum = $signed({s2_prod_q[49], s2_prod_q}) + s3_rnd;
    s3_r   = s3_sum >>> s2_shift_q;
    if (s2_relu_q && s3_r[50]) begin
      s3_byte = 8'h00;
    end else if (s3_r > 51'sd127) begin
      s3_byte = 8'h7f;
    end else if (s3_r < -51'sd128) begin
      s3_byte = 8'h80;
    end else begin
      s3_byte = s3_r[7:0];
    end
  end

  // Packer and flush control
  logic [23:0] pack_q, pack_d;
  logic [1:0]  count_q, count_d;
  logic        flush_pending_q, flush_pending_d;
  logic        flush_exec;
  logic        push;
  logic [31:0] push_data;
  logic [2:0]  push_bytes;

  // A res_valid this cycle still has to drain into the packer before the flush may run
  assign flush_exec = flush_pending_q & ~res_valid & ~s1_valid_q & ~s2_valid_q;

  always_comb begin
    pack_d          = pack_q;
    count_d         = count_q;
    push            = 1'b0;
    push_data       = '0;
    push_bytes      = '0;
    flush_pending_d = (flush_pending_q | flush) & ~flush_exec;
    if (s2_valid_q) begin
      if (count_q == 2'd3) begin
        push       = 1'b1;
        push_data  = {s3_byte, pack_q};
        push_bytes = 3'd4;
        pack_d     = '0;
        count_d    = 2'd0;
      end else begin
        case (count_q)
          2'd0:    pack_d[7:0]   = s3_byte;
          2'd1:    pack_d[15:8]  = s3_byte;
          default: pack_d[23:16] = s3_byte;
        endcase
        count_d = count_q + 2'd1;
      end
    end else if (flush_exec) begin
      push       = (count_q != 2'd0);
      push_data  = {8'h00, pack_q};
      push_bytes = {1'b0, count_q};
      pack_d     = '0;
      count_d    = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q          <= '0;
      count_q         <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      pack_q          <= pack_d;
      count_q         <= count_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  // Output FIFO
  logic [31:0]     mem_data  [FIFO_DEPTH];
  logic [2:0]      mem_bytes [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   fill_q;
  logic            overflow_q;
  logic            empty, full, pop, wr_en, drop;

  assign empty = (fill_q == '0);
  assign full  = (fill_q == FullCnt);
  assign pop   = ~empty & out_ready;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr_q]  <= push_data;
      mem_bytes[wr_ptr_q] <= push_bytes;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({wr_en, pop})
        2'b10:   fill_q <= fill_q + (PtrW + 1)'(1);
        2'b01:   fill_q <= fill_q - (PtrW + 1)'(1);
        default: fill_q <= fill_q;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign out_valid = ~empty;
  assign out_data  = empty ? 32'h0 : mem_data[rd_ptr_q];
  assign out_bytes = empty ? 3'd0 : mem_bytes[rd_ptr_q];
  assign overflow  = overflow_q;
  assign busy      = s1_valid_q | s2_valid_q | (count_q != 2'd0) | ~empty | flush_pending_q;

endmodule

// File: tb/tb_npu_result_requant_packer.sv
// Directed bench for npu_result_requant_packer: packing, requant arithmetic, flush, overflow, reset.
module tb_npu_result_requant_packer;

  logic        clk;
  logic        rst_n;
  logic [31:0] res_data;
  logic        res_valid;
  logic [31:0] bias;
  logic [15:0] scale_mult;
  logic [4:0]  scale_shift;
  logic        relu_en;
  logic        flush;
  logic        ovf_clr;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        busy;

  int total = 0;
  int bad   = 0;

  npu_result_requant_packer #(
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .res_data    (res_data),
    .res_valid   (res_valid),
    .bias        (bias),
    .scale_mult  (scale_mult),
    .scale_shift (scale_shift),
    .relu_en     (relu_en),
    .flush       (flush),
    .ovf_clr     (ovf_clr),
    .out_data    (out_data),
    .out_bytes   (out_bytes),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; holds res_valid for exactly one rising edge.
  task automatic put(input logic [31:0] d, input logic [31:0] b, input logic [15:0] m,
                     input logic [4:0] s, input logic r);
    res_data    = d;
    bias        = b;
    scale_mult  = m;
    scale_shift = s;
    relu_en     = r;
    res_valid   = 1'b1;
    @(negedge clk);
    res_valid   = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] ed, input logic [2:0] eb);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (out_valid) begin
      check_eq({tag, "_data"}, out_data, ed);
      check_eq({tag, "_bytes"}, 32'(out_bytes), 32'(eb));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; res_data = '0; res_valid = 1'b0; bias = '0; scale_mult = '0;
    scale_shift = '0; relu_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0; out_ready = 1'b0;
    idle(2);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'h0);
    check_eq("rst_out_bytes", 32'(out_bytes), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // 1: basic packing and latency
    put(32'd1, 0, 16'd1, 5'd0, 1'b0);
    put(32'd2, 0, 16'd1, 5'd0, 1'b0);
    put(32'd3, 0, 16'd1, 5'd0, 1'b0);
    put(32'd4, 0, 16'd1, 5'd0, 1'b0);
    check_eq("t1_lat1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq("t1_lat2", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq("t1_lat3", 32'(out_valid), 32'd1);
    expect_word("t1", 32'h04030201, 3'd4);

    // 2: saturation and ReLU
    put(32'd1000, 0, 16'd1, 5'd0, 1'b0);
    put(-32'sd1000, 0, 16'd1, 5'd0, 1'b0);
    put(-32'sd1000, 0, 16'd1, 5'd0, 1'b1);
    put(32'd100, 32'd27, 16'd1, 5'd0, 1'b0);
    expect_word("t2", 32'h7F00807F, 3'd4);

    // 3: rounding, then a word mixing large scale, negative saturation and 33-bit bias sum
    put(32'd3, 0, 16'd1, 5'd1, 1'b0);
    put(-32'sd3, 0, 16'd1, 5'd1, 1'b0);
    put(32'd5, 0, 16'd1, 5'd1, 1'b0);
    put(-32'sd5, 0, 16'd1, 5'd1, 1'b0);
    expect_word("t3a", 32'hFE03FF02, 3'd4);
    put(32'd10, 0, 16'd3, 5'd2, 1'b0);
    put(-32'sd200, 32'd50, 16'd300, 5'd8, 1'b0);
    put(32'h7FFFFFFF, 32'h7FFFFFFF, 16'd1, 5'd31, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    expect_word("t3b", 32'h00028008, 3'd3);

    // 4: flush on the cycle of the last result, then a flush with nothing packed
    put(32'h10, 0, 16'd1, 5'd0, 1'b0);
    flush = 1'b1;
    put(32'h20, 0, 16'd1, 5'd0, 1'b0);
    flush = 1'b0;
    expect_word("t4", 32'h00002010, 3'd2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle(6);
    check_eq("t4_empty_flush_valid", 32'(out_valid), 32'd0);
    check_eq("t4_empty_flush_busy", 32'(busy), 32'd0);
    check_eq("t4_overflow", 32'(overflow), 32'd0);

    // 5: overflow with a full FIFO, in-order drain, sticky clear
    for (int i = 1; i <= 12; i++) put(32'(i), 0, 16'd1, 5'd0, 1'b0);
    idle(4);
    check_eq("t5_overflow_set", 32'(overflow), 32'd1);
    expect_word("t5_w0", 32'h04030201, 3'd4);
    expect_word("t5_w1", 32'h08070605, 3'd4);
    check_eq("t5_drained", 32'(out_valid), 32'd0);
    check_eq("t5_overflow_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_eq("t5_overflow_clr", 32'(overflow), 32'd0);

    // 6: reset with one word queued, three bytes packed, two items in flight
    for (int i = 0; i < 9; i++) put(32'h11 + 32'(i), 0, 16'd1, 5'd0, 1'b0);
    check_eq("t6_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
    check_eq("t6_rst_data", out_data, 32'h0);
    check_eq("t6_rst_bytes", 32'(out_bytes), 32'd0);
    check_eq("t6_rst_overflow", 32'(overflow), 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    put(32'h21, 0, 16'd1, 5'd0, 1'b0);
    put(32'h22, 0, 16'd1, 5'd0, 1'b0);
    put(32'h23, 0, 16'd1, 5'd0, 1'b0);
    put(32'h24, 0, 16'd1, 5'd0, 1'b0);
    expect_word("t6", 32'h24232221, 3'd4);
    idle(6);
    check_eq("t6_no_stale", 32'(out_valid), 32'd0);
    check_eq("t6_idle_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
